// File: rtl/opc7_pkg.sv
// Shared definitions for the OPC7 32-bit CPU to 8-bit memory bridge:
// FSM state encoding, lane count and the legal wait-state range.
package opc7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int LANES           = 4;
  localparam int WAIT_STATES_MAX = 7;

  // Last wait-counter value of a byte lane; out-of-range settings saturate
  // so the 3-bit counter can always reach its terminal count.
  function automatic logic [2:0] wait_last(input int ws);
    if (ws > WAIT_STATES_MAX) begin
      return 3'(WAIT_STATES_MAX);
    end
    if (ws < 0) begin
      return 3'd0;
    end
    return 3'(ws);
  endfunction

endpackage

// File: rtl/opc7_mem8_bridge.sv
// Bridges a 32-bit word-addressed CPU bus onto an 8-bit byte-wide memory,
// splitting each word access into four little-endian byte cycles.
module opc7_mem8_bridge
  import opc7_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] cpu_addr,
  input  logic [31:0] cpu_dout,
  input  logic        cpu_rnw,
  input  logic        cpu_vpa,
  input  logic        cpu_vda,
  input  logic        cpu_vio,
  output logic [31:0] cpu_din,
  output logic        cpu_clken,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        io_sel,
  output logic        io_rnw,
  output logic [19:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata
);

  localparam logic [2:0] WAIT_LAST = wait_last(WAIT_STATES);

  state_t      state_reg, state_next;
  logic [1:0]  lane_reg, lane_next;
  logic [2:0]  wait_reg, wait_next;
  logic [19:0] addr_reg;
  logic [31:0] dout_reg;
  logic        rnw_reg;
  logic [31:0] asm_reg;
  logic [31:0] din_reg;

  logic        start;
  logic        lane_last;
  logic        io_cycle;
  logic        in_access;
  logic        in_done;
  logic [7:0]  dout_lanes [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign dout_lanes[gi] = dout_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    wait_next  = wait_reg;
    start      = 1'b0;
    lane_last  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // I/O qualifier wins: that cycle is passed straight through instead.
        if (!cpu_vio && (cpu_vpa || cpu_vda)) begin
          start      = 1'b1;
          state_next = ST_ACCESS;
          lane_next  = 2'd0;
          wait_next  = 3'd0;
        end
      end
      ST_ACCESS: begin
        if (wait_reg == WAIT_LAST) begin
          lane_last = 1'b1;
          wait_next = 3'd0;
          if (lane_reg == 2'd3) begin
            state_next = ST_DONE;
            lane_next  = 2'd0;
          end else begin
            lane_next = lane_reg + 2'd1;
          end
        end else begin
          wait_next = wait_reg + 3'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      lane_reg  <= 2'd0;
      wait_reg  <= 3'd0;
      addr_reg  <= '0;
      dout_reg  <= '0;
      rnw_reg   <= 1'b0;
      asm_reg   <= '0;
      din_reg   <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      wait_reg  <= wait_next;
      if (start) begin
        addr_reg <= cpu_addr;
        dout_reg <= cpu_dout;
        rnw_reg  <= cpu_rnw;
      end
      if (lane_last && rnw_reg) begin
        asm_reg[8*lane_reg +: 8] <= mem_rdata;
      end
      // Read word is held for the CPU once the access completes.
      if (state_reg == ST_DONE && rnw_reg) begin
        din_reg <= asm_reg;
      end
    end
  end

  // Reset gates the combinational outputs so nothing leaks while it is held.
  assign io_cycle  = !reset && (state_reg == ST_IDLE) && cpu_vio;
  assign in_access = !reset && (state_reg == ST_ACCESS);
  assign in_done   = !reset && (state_reg == ST_DONE);

  assign cpu_clken = !(in_access || (start && !reset));

  assign mem_ce    = in_access;
  assign mem_oe    = in_access && rnw_reg;
  assign mem_we    = in_access && !rnw_reg;
  assign mem_addr  = in_access ? {addr_reg, lane_reg} : 22'd0;
  assign mem_wdata = in_access ? dout_lanes[lane_reg] : 8'd0;

  assign io_sel    = io_cycle;
  assign io_rnw    = io_cycle ? cpu_rnw : 1'b1;
  assign io_addr   = cpu_addr;
  assign io_wdata  = cpu_dout;

  assign cpu_din   = reset    ? 32'd0 :
                     io_cycle ? io_rdata :
                     in_done  ? asm_reg : din_reg;

endmodule

// File: tb/tb_opc7_mem8_bridge.sv
// Self-checking bench: a transaction-level model expands each CPU cycle into
// the per-clock outputs it must produce; a negedge process compares them.
module tb_opc7_mem8_bridge;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] cpu_addr;
  logic [31:0] cpu_dout;
  logic        cpu_rnw, cpu_vpa, cpu_vda, cpu_vio;
  logic [31:0] cpu_din;
  logic        cpu_clken;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ce, mem_oe, mem_we;
  logic        io_sel, io_rnw;
  logic [19:0] io_addr;
  logic [31:0] io_wdata, io_rdata;

  // second instance with zero wait states
  logic [19:0] addr0;
  logic        vda0;
  logic [31:0] din0;
  logic        clken0;
  logic [21:0] maddr0;
  logic [7:0]  wdata0, rdata0;
  logic        ce0, oe0, we0, iosel0, iornw0;
  logic [19:0] ioaddr0;
  logic [31:0] iowdata0;

  logic [7:0]  ram     [256];
  logic [7:0]  ref_mem [256];

  typedef struct packed {
    logic        clken, ce, oe, we, io_sel, io_rnw, chk_addr;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [31:0] din;
    logic [19:0] io_addr;
    logic [31:0] io_wdata;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  logic [31:0] last_din;
  int          vectors = 0;
  int          miscompares = 0;
  int          run_len = 0;
  int          last_run = 0;
  int          hi_cnt = 0;

  always #5 clk = ~clk;

  opc7_mem8_bridge #(.WAIT_STATES(W)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
    .cpu_vpa(cpu_vpa), .cpu_vda(cpu_vda), .cpu_vio(cpu_vio),
    .cpu_din(cpu_din), .cpu_clken(cpu_clken),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we),
    .io_sel(io_sel), .io_rnw(io_rnw), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  opc7_mem8_bridge #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_addr(addr0), .cpu_dout(32'd0), .cpu_rnw(1'b1),
    .cpu_vpa(1'b0), .cpu_vda(vda0), .cpu_vio(1'b0),
    .cpu_din(din0), .cpu_clken(clken0),
    .mem_addr(maddr0), .mem_wdata(wdata0), .mem_rdata(rdata0),
    .mem_ce(ce0), .mem_oe(oe0), .mem_we(we0),
    .io_sel(iosel0), .io_rnw(iornw0), .io_addr(ioaddr0),
    .io_wdata(iowdata0), .io_rdata(32'd0)
  );

  // byte-wide memory seen by the DUT pins
  assign mem_rdata = ram[mem_addr[7:0]];
  assign rdata0    = ram[maddr0[7:0]];
  always @(posedge clk) begin
    if (mem_ce && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      cur = expq.pop_front();
      chk("cpu_clken", 32'(cpu_clken), 32'(cur.clken));
      chk("mem_ce", 32'(mem_ce), 32'(cur.ce));
      chk("mem_oe", 32'(mem_oe), 32'(cur.oe));
      chk("mem_we", 32'(mem_we), 32'(cur.we));
      chk("io_sel", 32'(io_sel), 32'(cur.io_sel));
      chk("cpu_din", cpu_din, cur.din);
      if (cur.chk_addr) chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
      if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      if (cur.io_sel) begin
        chk("io_rnw", 32'(io_rnw), 32'(cur.io_rnw));
        chk("io_addr", 32'(io_addr), 32'(cur.io_addr));
        chk("io_wdata", io_wdata, cur.io_wdata);
      end
    end
  end

  // clken low-run length and high-cycle count
  always @(negedge clk) begin
    if (!cpu_clken) begin
      run_len <= run_len + 1;
    end else begin
      if (run_len != 0) last_run <= run_len;
      run_len <= 0;
      hi_cnt  <= hi_cnt + 1;
    end
  end

  function automatic exp_t base_exp();
    exp_t e;
    e = '0;
    e.clken = 1'b1;
    e.din   = last_din;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '0;
    e.clken    = 1'b1;
    e.chk_addr = 1'b1;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    cpu_addr = 20'($urandom);
    cpu_dout = $urandom;
    cpu_rnw  = 1'($urandom);
    cpu_vpa  = 1'($urandom);
    cpu_vda  = 1'($urandom);
    cpu_vio  = 1'($urandom);
    io_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_vpa = 1'b0; cpu_vda = 1'b0; cpu_vio = 1'b0;
      expq.push_back(base_exp());
      next_cycle();
    end
  endtask

  // One CPU word access: a stall cycle, four lanes of W+1 cycles, one DONE.
  task automatic do_mem(input logic [19:0] a, input logic [31:0] d, input logic rnw, input logic fetch);
    exp_t        e;
    logic [31:0] word;
    int          idx;
    cpu_addr = a; cpu_dout = d; cpu_rnw = rnw;
    cpu_vpa = fetch; cpu_vda = ~fetch; cpu_vio = 1'b0;
    e = base_exp();
    e.clken = 1'b0;
    expq.push_back(e);
    next_cycle();
    word = '0;
    for (int l = 0; l < 4; l++) begin
      idx = (int'(a) * 4 + l) % 256;
      if (rnw) word[8*l +: 8] = ref_mem[idx];
      else     ref_mem[idx] = d[8*l +: 8];
      for (int w = 0; w <= W; w++) begin
        scramble();
        e = base_exp();
        e.clken = 1'b0; e.ce = 1'b1; e.oe = rnw; e.we = ~rnw;
        e.chk_addr = 1'b1; e.addr = {a, 2'(l)}; e.wdata = d[8*l +: 8];
        expq.push_back(e);
        next_cycle();
      end
    end
    cpu_vpa = 1'b0; cpu_vda = 1'b0; cpu_vio = 1'b0;
    e = base_exp();
    if (rnw) e.din = word;
    expq.push_back(e);
    if (rnw) last_din = word;
    next_cycle();
  endtask

  // Drives one I/O cycle and queues its expectation; caller advances the clock.
  task automatic do_io(input logic [19:0] a, input logic [31:0] d, input logic rnw,
                       input logic [31:0] rd, input logic also_mem);
    exp_t e;
    cpu_addr = a; cpu_dout = d; cpu_rnw = rnw;
    cpu_vio = 1'b1; cpu_vpa = also_mem; cpu_vda = 1'b0; io_rdata = rd;
    e = base_exp();
    e.io_sel = 1'b1; e.io_rnw = rnw; e.io_addr = a; e.io_wdata = d; e.din = rd;
    expq.push_back(e);
  endtask

  // Write aborted by reset in the first cycle of lane 2.
  task automatic reset_mid_write(input logic [19:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    cpu_addr = a; cpu_dout = d; cpu_rnw = 1'b0;
    cpu_vpa = 1'b0; cpu_vda = 1'b1; cpu_vio = 1'b0;
    e = base_exp();
    e.clken = 1'b0;
    expq.push_back(e);
    next_cycle();
    for (int l = 0; l < 2; l++) begin
      idx = (int'(a) * 4 + l) % 256;
      ref_mem[idx] = d[8*l +: 8];
      for (int w = 0; w <= W; w++) begin
        scramble();
        e = base_exp();
        e.clken = 1'b0; e.ce = 1'b1; e.we = 1'b1;
        e.chk_addr = 1'b1; e.addr = {a, 2'(l)}; e.wdata = d[8*l +: 8];
        expq.push_back(e);
        next_cycle();
      end
    end
    scramble();
    reset = 1'b1;
    last_din = '0;
    expq.push_back(reset_exp());
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_clken", 32'(cpu_clken), 32'd1);
    chk("abort_mem_ce", 32'(mem_ce), 32'd0);
    next_cycle();
    expq.push_back(reset_exp());
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic zero_wait_read();
    addr0 = 20'h00010;
    vda0  = 1'b1;
    @(negedge clk);
    chk("w0_start_clken", 32'(clken0), 32'd0);
    chk("w0_start_ce", 32'(ce0), 32'd0);
    next_cycle();
    vda0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w0_clken", 32'(clken0), 32'd0);
      chk("w0_ce", 32'(ce0), 32'd1);
      chk("w0_addr", 32'(maddr0), 32'h40 + 32'(i));
      next_cycle();
    end
    @(negedge clk);
    chk("w0_done_clken", 32'(clken0), 32'd1);
    chk("w0_done_din", din0, 32'h44332211);
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ram[8'h40] = 8'h11; ram[8'h41] = 8'h22; ram[8'h42] = 8'h33; ram[8'h43] = 8'h44;
    ref_mem[8'h40] = 8'h11; ref_mem[8'h41] = 8'h22; ref_mem[8'h42] = 8'h33; ref_mem[8'h43] = 8'h44;
    last_din = '0;
    reset = 1'b1;
    cpu_addr = '0; cpu_dout = '0; cpu_rnw = 1'b1;
    cpu_vpa = 1'b0; cpu_vda = 1'b0; cpu_vio = 1'b0; io_rdata = '0;
    addr0 = '0; vda0 = 1'b0;

    next_cycle();
    expq.push_back(reset_exp());
    next_cycle();
    expq.push_back(reset_exp());
    next_cycle();
    reset = 1'b0;
    idle(2);

    do_mem(20'h00010, 32'h0, 1'b1, 1'b0);
    chk("read_clken_low_run", 32'(last_run), 32'd9);
    chk("read_word_literal", last_din, 32'h44332211);

    do_mem(20'h00003, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("write_clken_low_run", 32'(last_run), 32'd9);
    chk("write_byte_0c", 32'(ram[8'h0C]), 32'hEF);
    chk("write_byte_0d", 32'(ram[8'h0D]), 32'hBE);
    chk("write_byte_0e", 32'(ram[8'h0E]), 32'hAD);
    chk("write_byte_0f", 32'(ram[8'h0F]), 32'hDE);

    do_io(20'h12345, 32'h0, 1'b1, 32'h0000005A, 1'b0);
    #1;
    chk("io_din_literal", cpu_din, 32'h0000005A);
    chk("io_clken_literal", 32'(cpu_clken), 32'd1);
    chk("io_sel_literal", 32'(io_sel), 32'd1);
    chk("io_mem_ce_literal", 32'(mem_ce), 32'd0);
    next_cycle();
    do_io(20'h0ABCD, 32'h12345678, 1'b0, 32'hFFFF0000, 1'b0);
    next_cycle();
    do_io(20'h00007, 32'hA5A5A5A5, 1'b1, 32'h0BADF00D, 1'b1);
    next_cycle();
    idle(1);

    h0 = hi_cnt;
    do_mem(20'h00010, 32'h0, 1'b1, 1'b1);
    do_mem(20'h00003, 32'h0, 1'b1, 1'b0);
    chk("b2b_clken_high_cycles", 32'(hi_cnt - h0), 32'd2);
    chk("b2b_word_literal", last_din, 32'hDEADBEEF);
    idle(1);

    reset_mid_write(20'h00005, 32'hCAFEF00D);
    do_mem(20'h00005, 32'h0, 1'b1, 1'b0);
    do_mem(20'h00020, 32'h01020304, 1'b0, 1'b0);
    do_mem(20'h00020, 32'h0, 1'b1, 1'b1);
    chk("rw_roundtrip_literal", last_din, 32'h01020304);
    idle(2);

    zero_wait_read();
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
